// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared types and sizing helpers for the iterative restoring divider.
//   Contents:
//     div_state_t       FSM state encoding (IDLE, RUN, DONE)
//     DEFAULT_WIDTH     operand width used when the top is not overridden
//     DEFAULT_CNT_WIDTH iteration counter width for DEFAULT_WIDTH
//     cnt_width()       iteration counter width for any WIDTH: $clog2(WIDTH)+1
// -----------------------------------------------------------------------------
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEFAULT_WIDTH     = 4;
    localparam int DEFAULT_CNT_WIDTH = $clog2(DEFAULT_WIDTH) + 1;

    // One spare bit keeps the counter wide enough to hold WIDTH-1 for any WIDTH,
    // including exact powers of two.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
//   One combinational iteration of restoring division.
//   The pair {rem, q} is shifted left by one bit, and divisor is subtracted from
//   the upper part on a trial basis. When the trial result is non-negative, it
//   becomes the new partial remainder and a 1 enters the quotient. Otherwise the
//   shifted remainder is kept and a 0 enters the quotient.
// Ports:
//   rem       in   WIDTH+1  current partial remainder
//   q         in   WIDTH    current quotient / remaining dividend bits
//   divisor   in   WIDTH    divisor magnitude
//   next_rem  out  WIDTH+1  partial remainder after this iteration
//   next_q    out  WIDTH    quotient register after this iteration
// -----------------------------------------------------------------------------
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic [WIDTH-1:0] next_q
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   trial;
    logic             fits;

    // The compare is done at full width, so the subtraction only needs WIDTH+1 bits.
    // Whenever the divisor fits, the shifted value is below 2*divisor, which keeps
    // the top bit clear.
    always_comb begin
        shifted  = {rem, q[WIDTH-1]};
        fits     = (shifted >= {2'b00, divisor});
        trial    = shifted[WIDTH:0] - {1'b0, divisor};
        next_rem = shifted[WIDTH:0];
        next_q   = {q[WIDTH-2:0], 1'b0};
        if (fits) begin
            next_rem = trial;
            next_q   = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/sequential_divider.sv
// -----------------------------------------------------------------------------
// sequential_divider
//   Iterative restoring divider that produces one quotient bit per clock.
//   A division accepted at edge E0 shows done=1 after edge E_WIDTH.
//   When the divisor is zero, the module finishes at the accepting edge. In that
//   case quotient is all ones, remainder equals dividend, and div_by_zero is set.
//   Optional feature macro: DIVIDER_SIGNED_EN
//     Defined   : operands are two's complement, and division truncates toward
//                 zero. The remainder takes the sign of the dividend. MIN / -1
//                 wraps to MIN with remainder 0.
//     Undefined : operands are unsigned, and no sign logic is built.
// Ports:
//   clk          in   1      clock, rising edge
//   rst_n        in   1      synchronous active-low reset
//   start        in   1      accept operands (ignored while busy)
//   dividend     in   WIDTH  numerator, sampled on accepted start
//   divisor      in   WIDTH  denominator, sampled on accepted start
//   quotient     out  WIDTH  quotient, valid while done=1
//   remainder    out  WIDTH  remainder, valid while done=1
//   busy         out  1      division in progress
//   done         out  1      results valid until next accepted start
//   div_by_zero  out  1      last accepted operation had a zero divisor
// -----------------------------------------------------------------------------
module sequential_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] div_reg;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_q;

    logic [WIDTH-1:0] load_dividend;
    logic [WIDTH-1:0] load_divisor;
    logic [WIDTH-1:0] final_quot;
    logic [WIDTH-1:0] final_rem;

    divider_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_reg),
        .q       (q_reg),
        .divisor (div_reg),
        .next_rem(step_rem),
        .next_q  (step_q)
    );

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // The core always divides magnitudes. Negating MIN leaves MIN, which is the
    // correct unsigned magnitude, so MIN / -1 wraps back to MIN without any
    // special-case logic.
    always_comb begin
        load_dividend = dividend[WIDTH-1] ? -dividend : dividend;
        load_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
        final_quot    = neg_q ? -step_q : step_q;
        final_rem     = neg_r ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
    end

    // Result signs are captured together with the operands. They are applied only
    // when the last iteration writes the output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start && (state != RUN) && (divisor != '0)) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    always_comb begin
        load_dividend = dividend;
        load_divisor  = divisor;
        final_quot    = step_q;
        final_rem     = step_rem[WIDTH-1:0];
    end
`endif

    // Main control FSM.
    // The quotient/remainder outputs are written only on entry to DONE, so they
    // keep the previous result throughout IDLE and RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem_reg     <= '0;
            q_reg       <= '0;
            div_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            state       <= RUN;
                            count       <= '0;
                            rem_reg     <= '0;
                            q_reg       <= load_dividend;
                            div_reg     <= load_divisor;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            div_by_zero <= 1'b0;
                        end else begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_reg <= step_rem;
                    q_reg   <= step_q;
                    if (count == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= final_quot;
                        remainder <= final_rem;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
